// File: rtl/rggen_apb_responder.sv
// ============================================================================
// rggen_apb_responder : APB4 completer that issues in-window transfers as rggen bus requests
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module rggen_apb_responder #(
  parameter int                       ADDRESS_WIDTH = 16,
  parameter int                       BUS_WIDTH     = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = '0,
  parameter int                       BYTE_SIZE     = 256
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  // APB4 completer side
  input  logic                       i_psel,
  input  logic                       i_penable,
  input  logic [ADDRESS_WIDTH-1:0]   i_paddr,
  input  logic [2:0]                 i_pprot,
  input  logic                       i_pwrite,
  input  logic [BUS_WIDTH/8-1:0]     i_pstrb,
  input  logic [BUS_WIDTH-1:0]       i_pwdata,
  output logic                       o_pready,
  output logic [BUS_WIDTH-1:0]       o_prdata,
  output logic                       o_pslverr,
  // rggen bus master side
  output logic                       o_bus_valid,
  output logic [ADDRESS_WIDTH-1:0]   o_bus_address,
  output logic                       o_bus_write,
  output logic [BUS_WIDTH-1:0]       o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]     o_bus_strobe,
  input  logic                       i_bus_ready,
  input  logic [1:0]                 i_bus_status,
  input  logic [BUS_WIDTH-1:0]       i_bus_read_data
);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_access  = 2'd1;
  localparam logic [1:0] c_respond = 2'd2;

  localparam int c_lsb = $clog2(BUS_WIDTH / 8);

  // One extra bit so the window end never wraps around the address space.
  localparam logic [ADDRESS_WIDTH:0] c_window_lo   = {1'b0, BASE_ADDRESS};
  localparam logic [ADDRESS_WIDTH:0] c_window_size = (ADDRESS_WIDTH + 1)'(BYTE_SIZE);
  localparam logic [ADDRESS_WIDTH:0] c_window_hi   = c_window_lo + c_window_size;

  logic [1:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     write_q, write_d;
  logic [BUS_WIDTH-1:0]     wdata_q, wdata_d;
  logic [BUS_WIDTH/8-1:0]   strb_q, strb_d;
  logic                     err_q, err_d;
  logic [BUS_WIDTH-1:0]     rdata_q, rdata_d;

  logic w_hit;
  logic w_unused_inputs;

  assign w_hit = ({1'b0, i_paddr} >= c_window_lo) &&
                 ({1'b0, i_paddr} <  c_window_hi) &&
                 (i_paddr[c_lsb-1:0] == '0);

  assign w_unused_inputs = ^{i_penable, i_pprot, i_bus_status[0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= c_idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle:    if (i_psel) state_d = w_hit ? c_access : c_respond;
      c_access:  if (i_bus_ready) state_d = c_respond;
      c_respond: state_d = c_idle;
      default:   state_d = c_idle;
    endcase
  end

  always_comb begin
    o_bus_valid      = 1'b0;
    o_bus_address    = '0;
    o_bus_write      = 1'b0;
    o_bus_write_data = '0;
    o_bus_strobe     = '0;
    o_pready         = 1'b0;
    o_pslverr        = 1'b0;
    o_prdata         = '0;
    case (state_q)
      c_access: begin
        o_bus_valid      = 1'b1;
        o_bus_address    = addr_q;
        o_bus_write      = write_q;
        o_bus_write_data = wdata_q;
        o_bus_strobe     = write_q ? strb_q : '0;
      end
      c_respond: begin
        o_pready  = 1'b1;
        o_pslverr = err_q;
        o_prdata  = rdata_q;
      end
      default: ;
    endcase
  end

  // Request capture in IDLE, response capture when the bus completes.
  always_comb begin
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      c_idle: begin
        if (i_psel) begin
          addr_d  = i_paddr;
          write_d = i_pwrite;
          wdata_d = i_pwdata;
          strb_d  = i_pstrb;
          err_d   = !w_hit;
          rdata_d = '0;
        end
      end
      c_access: begin
        if (i_bus_ready) begin
          err_d   = i_bus_status[1];
          rdata_d = (!write_q && !i_bus_status[1]) ? i_bus_read_data : '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rggen_apb_responder.sv
// ============================================================================
// tb_rggen_apb_responder : scoreboard bench for the APB-to-rggen responder
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_rggen_apb_responder;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_psel = 1'b0;
  logic        i_penable = 1'b0;
  logic [15:0] i_paddr = '0;
  logic [2:0]  i_pprot = '0;
  logic        i_pwrite = 1'b0;
  logic [3:0]  i_pstrb = '0;
  logic [31:0] i_pwdata = '0;
  logic        o_pready;
  logic [31:0] o_prdata;
  logic        o_pslverr;
  logic        o_bus_valid;
  logic [15:0] o_bus_address;
  logic        o_bus_write;
  logic [31:0] o_bus_write_data;
  logic [3:0]  o_bus_strobe;
  logic        i_bus_ready = 1'b0;
  logic [1:0]  i_bus_status = '0;
  logic [31:0] i_bus_read_data = '0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [52:0] bus_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  rggen_apb_responder #(
    .ADDRESS_WIDTH (16),
    .BUS_WIDTH     (32),
    .BASE_ADDRESS  (16'h0100),
    .BYTE_SIZE     (256)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (i_rst_n),
    .i_psel           (i_psel),
    .i_penable        (i_penable),
    .i_paddr          (i_paddr),
    .i_pprot          (i_pprot),
    .i_pwrite         (i_pwrite),
    .i_pstrb          (i_pstrb),
    .i_pwdata         (i_pwdata),
    .o_pready         (o_pready),
    .o_prdata         (o_prdata),
    .o_pslverr        (o_pslverr),
    .o_bus_valid      (o_bus_valid),
    .o_bus_address    (o_bus_address),
    .o_bus_write      (o_bus_write),
    .o_bus_write_data (o_bus_write_data),
    .o_bus_strobe     (o_bus_strobe),
    .i_bus_ready      (i_bus_ready),
    .i_bus_status     (i_bus_status),
    .i_bus_read_data  (i_bus_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Monitor: pops bus requests on the first valid cycle and APB responses on pready.
  initial begin : g_monitor
    logic [52:0] cur;
    logic        valid_prev;
    rsp_t        e;
    cur = '0;
    valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (o_bus_valid) begin
        if (!valid_prev) begin
          check("bus_q_nonempty", 128'(bus_q.size() != 0), 128'(1));
          if (bus_q.size() != 0) cur = bus_q.pop_front();
        end
        check("bus_req", 128'({o_bus_address, o_bus_write, o_bus_write_data, o_bus_strobe}), 128'(cur));
      end else begin
        check("bus_idle_zero", 128'({o_bus_address, o_bus_write, o_bus_write_data, o_bus_strobe}), 128'(0));
      end
      valid_prev = o_bus_valid;
      if (o_pready) begin
        check("rsp_q_nonempty", 128'(rsp_q.size() != 0), 128'(1));
        if (rsp_q.size() != 0) begin
          e = rsp_q.pop_front();
          check("pslverr", 128'(o_pslverr), 128'(e.err));
          check("prdata", 128'(o_prdata), 128'(e.rdata));
          check("pready_cycle", 128'(cyc), 128'(e.cyc));
        end
      end else begin
        check("apb_idle_zero", 128'({o_pslverr, o_prdata}), 128'(0));
      end
    end
  end

  task automatic idle(input int n);
    i_psel = 1'b0;
    i_penable = 1'b0;
    repeat (n) begin
      i_bus_ready = 1'($urandom);
      i_bus_status = 2'($urandom);
      i_bus_read_data = $urandom;
      @(posedge clk);
      #1;
    end
    i_bus_ready = 1'b0;
  endtask

  // Drives one transfer starting with setup in the current cycle; returns just after
  // the edge that ends the completion cycle, with psel still asserted.
  task automatic xfer(input logic [15:0] a, input logic wr, input logic [31:0] wd,
                      input logic [3:0] sb, input int dly, input logic [1:0] st,
                      input logic [31:0] rd);
    bit   hit;
    bit   got;
    rsp_t e;
    hit = (a >= 16'h0100) && (a < 16'h0200) && (a[1:0] == 2'b00);
    i_psel = 1'b1;
    i_penable = 1'b0;
    i_paddr = a;
    i_pwrite = wr;
    i_pwdata = wd;
    i_pstrb = sb;
    i_pprot = 3'($urandom);
    i_bus_ready = 1'($urandom);
    e.err = hit ? st[1] : 1'b1;
    e.rdata = (hit && !wr && !st[1]) ? rd : 32'h0;
    e.cyc = cyc + (hit ? dly + 2 : 1);
    rsp_q.push_back(e);
    if (hit) bus_q.push_back({a, wr, wd, wr ? sb : 4'h0});
    @(posedge clk);
    #1;
    i_penable = 1'b1;
    i_bus_ready = 1'b0;
    if (hit) begin
      for (int k = 0; k <= dly; k++) begin
        i_bus_ready = (k == dly);
        i_bus_status = st;
        i_bus_read_data = (k == dly) ? rd : $urandom;
        @(posedge clk);
        #1;
      end
      i_bus_ready = 1'b0;
    end
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_pready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("pready_seen", 128'(got), 128'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin : g_stim
    logic [15:0] a;
    #1;
    check("reset_outputs", 128'({o_pready, o_pslverr, o_prdata, o_bus_valid, o_bus_address,
                                 o_bus_write, o_bus_write_data, o_bus_strobe}), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    idle(4);

    xfer(16'h0104, 1'b1, 32'hDEADBEEF, 4'hF, 2, 2'b00, 32'h0);
    idle(2);
    xfer(16'h01FC, 1'b0, 32'h0, 4'h0, 0, 2'b00, 32'h12345678);
    idle(2);
    xfer(16'h00FC, 1'b0, 32'h0, 4'h0, 0, 2'b00, 32'hAAAA5555);
    idle(1);
    xfer(16'h0200, 1'b1, 32'h11112222, 4'h3, 0, 2'b00, 32'h0);
    idle(1);
    xfer(16'h0102, 1'b0, 32'h0, 4'h0, 0, 2'b00, 32'h5A5A5A5A);
    idle(1);
    xfer(16'h0100, 1'b0, 32'h0, 4'h0, 1, 2'b10, 32'hFFFFFFFF);
    idle(1);
    xfer(16'h0180, 1'b0, 32'h0, 4'h0, 3, 2'b11, 32'hCAFEF00D);
    idle(1);
    xfer(16'h0184, 1'b0, 32'h0, 4'h0, 1, 2'b01, 32'h0BADC0DE);
    idle(1);
    xfer(16'h0188, 1'b1, 32'h01020304, 4'h5, 0, 2'b10, 32'h0);
    idle(1);

    // Back-to-back: next setup in the cycle right after the completion.
    xfer(16'h0108, 1'b1, 32'hA5A5F00F, 4'hC, 1, 2'b00, 32'h0);
    xfer(16'h010C, 1'b0, 32'h0, 4'h0, 0, 2'b00, 32'h87654321);
    xfer(16'h0300, 1'b0, 32'h0, 4'h0, 0, 2'b00, 32'h0);
    xfer(16'h01F8, 1'b0, 32'h0, 4'h0, 2, 2'b00, 32'h13579BDF);
    idle(2);

    // Reset asserted mid-ACCESS.
    i_psel = 1'b1;
    i_penable = 1'b0;
    i_paddr = 16'h0110;
    i_pwrite = 1'b0;
    i_pstrb = 4'h0;
    i_pwdata = 32'h0;
    bus_q.push_back({16'h0110, 1'b0, 32'h0, 4'h0});
    @(posedge clk);
    #1;
    i_penable = 1'b1;
    @(negedge clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("rst_async_valid", 128'(o_bus_valid), 128'(0));
    check("rst_async_pready", 128'(o_pready), 128'(0));
    i_psel = 1'b0;
    i_penable = 1'b0;
    @(posedge clk);
    #1;
    check("rst_held_valid", 128'(o_bus_valid), 128'(0));
    i_rst_n = 1'b1;
    idle(3);
    check("bus_q_drained", 128'(bus_q.size()), 128'(0));
    xfer(16'h0114, 1'b0, 32'h0, 4'h0, 1, 2'b00, 32'h2468ACE0);
    idle(1);

    for (int n = 0; n < 12; n++) begin
      a = 16'($urandom_range(16'h00E0, 16'h0220));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      xfer(a, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 3)),
           2'($urandom), $urandom);
      if ($urandom_range(0, 1) != 0) idle(int'($urandom_range(1, 2)));
    end
    idle(4);
    check("rsp_q_drained", 128'(rsp_q.size()), 128'(0));
    check("bus_q_final", 128'(bus_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : g_watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
